uart_tx: RTL and testbench

Transmit half of the UART: accepts bytes from a host-side valid/ready interface into an internal 8-deep FIFO and serializes them on `tx` at the bit rate set by the `tck` strobe. The frame is 1 start bit, 8 data bits LSB first, 1 even-parity bit and 1 stop bit, bit-compatible with `uart_rx`. It sits beside `uart_rx` in the UART top and shares the `uart_defs` package.

---
 rtl/uart_defs.sv | 19 +
 rtl/fifo.sv | 64 ++++++
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART types: TX interrupt flags and serializer states
package uart_defs;

  localparam int unsigned DATA_BITS = 8;

  typedef struct packed {
    logic fifo_empty;
    logic frame_done;
  } TXIrqFlags_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } TxState_t;

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - synchronous FIFO with valid/ready enqueue and dequeue handshakes
module fifo #(
  parameter int data_size   = 8,
  parameter int buffer_size = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [data_size-1:0] enq_data,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  output logic [data_size-1:0] deq_data,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(buffer_size);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(buffer_size);

  logic [data_size-1:0] mem [buffer_size];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 enq_fire;
  logic                 deq_fire;

  // Full/empty come from the registered count, so a pop frees a slot only next cycle.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign deq_data  = mem[rd_ptr];
  assign enq_fire  = enq_valid && !full;
  assign deq_fire  = deq_ready && !empty;

  // Pointer and occupancy bookkeeping; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + AW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage needs no reset; only slots below count are ever read out.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: byte FIFO plus 8E1 serializer paced by tck
module uart_tx
  import uart_defs::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tck,
  output logic        tx,
  input  logic [7:0]  txfifo_data,
  input  logic        txfifo_valid,
  output logic        txfifo_ready,
  output logic        txfifo_full,
  output logic        txfifo_empty,
  output logic        busy,
  output TXIrqFlags_t tx_irq_flags
);

  TxState_t   state, state_n;
  logic [7:0] shreg, shreg_n;
  logic       par, par_n;
  logic [2:0] cnt, cnt_n;
  logic [2:0] nidx;
  logic       tx_q, tx_n;
  logic       busy_q;
  logic       pop;
  logic       frame_done;
  logic [7:0] head_data;
  logic       head_valid;

  fifo #(
    .data_size   (8),
    .buffer_size (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .enq_data  (txfifo_data),
    .enq_valid (txfifo_valid),
    .enq_ready (txfifo_ready),
    .deq_data  (head_data),
    .deq_valid (head_valid),
    .deq_ready (pop),
    .full      (txfifo_full),
    .empty     (txfifo_empty)
  );

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign nidx         = cnt + 3'd1;
  assign tx_irq_flags = '{fifo_empty: txfifo_empty, frame_done: frame_done};

  // Serializer registers; the state names the bit currently driven on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      par    <= 1'b0;
      cnt    <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      par    <= par_n;
      cnt    <= cnt_n;
      tx_q   <= tx_n;
      busy_q <= (state_n != IDLE);
    end
  end

  // Next-bit selection; nothing moves unless tck is high. STOP chains straight into START.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    par_n      = par;
    cnt_n      = cnt;
    tx_n       = tx_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    if (tck) begin
      case (state)
        IDLE: begin
          tx_n = 1'b1;
          if (head_valid) begin
            pop     = 1'b1;
            shreg_n = head_data;
            par_n   = 1'b0;
            cnt_n   = '0;
            tx_n    = 1'b0;
            state_n = START;
          end
        end
        START: begin
          tx_n    = shreg[0];
          par_n   = par ^ shreg[0];
          state_n = SHIFT;
        end
        SHIFT: begin
          if (cnt != 3'(DATA_BITS - 1)) begin
            tx_n  = shreg[nidx];
            par_n = par ^ shreg[nidx];
            cnt_n = nidx;
          end else begin
            tx_n    = par;
            state_n = PARITY;
          end
        end
        PARITY: begin
          tx_n    = 1'b1;
          state_n = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          if (head_valid) begin
            pop     = 1'b1;
            shreg_n = head_data;
            par_n   = 1'b0;
            cnt_n   = '0;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          tx_n    = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with line decoder and byte scoreboard
module tb_uart_tx;
  import uart_defs::*;

  localparam int TCK_DIV = 16;
  localparam int BUDGET  = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tck = 1'b0;
  logic        tx;
  logic [7:0]  txfifo_data = 8'h00;
  logic        txfifo_valid = 1'b0;
  logic        txfifo_ready;
  logic        txfifo_full;
  logic        txfifo_empty;
  logic        busy;
  TXIrqFlags_t tx_irq_flags;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t vecs[8];

  int   tests = 0;
  int   fails = 0;
  bit   tck_en = 1'b0;
  int   div = 0;

  int         mstate = 0;
  int         mbits = 0;
  int         b2b = 0;
  int         fd_count = 0;
  int         frames = 0;
  bit         prev_stop = 1'b0;
  logic [7:0] mdata = 8'h00;
  logic       mpar = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tck          (tck),
    .tx           (tx),
    .txfifo_data  (txfifo_data),
    .txfifo_valid (txfifo_valid),
    .txfifo_ready (txfifo_ready),
    .txfifo_full  (txfifo_full),
    .txfifo_empty (txfifo_empty),
    .busy         (busy),
    .tx_irq_flags (tx_irq_flags)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Bit-rate strobe: one clk high every TCK_DIV clk while enabled.
  always @(negedge clk) begin
    if (!tck_en) begin
      div = 0;
      tck = 1'b0;
    end else if (div == TCK_DIV - 1) begin
      div = 0;
      tck = 1'b1;
    end else begin
      div++;
      tck = 1'b0;
    end
  end

  // Line decoder: samples the bit that ends at each tck edge and scores whole frames.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      mstate    = 0;
      mbits     = 0;
      prev_stop = 1'b0;
    end else begin
      if (tx_irq_flags.frame_done) fd_count++;
      if (tck) begin
        case (mstate)
          0: begin
            if (tx == 1'b0) begin
              if (prev_stop) b2b++;
              mstate = 1;
              mbits  = 0;
            end
            prev_stop = 1'b0;
          end
          1: begin
            mdata[mbits] = tx;
            mbits++;
            if (mbits == 8) mstate = 2;
          end
          2: begin
            mpar   = tx;
            mstate = 3;
          end
          default: begin
            check("stop_bit", tx, 1);
            check("frame_done_at_stop", tx_irq_flags.frame_done, 1);
            if (sb.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_frame: got byte %0h, required no frame", mdata);
            end else begin
              mon_e = sb.pop_front();
              check("rx_data", mdata, mon_e.data);
              check("rx_parity", mpar, mon_e.par);
            end
            frames++;
            mstate    = 0;
            prev_stop = 1'b1;
          end
        endcase
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.par  = p;
    sb.push_back(e);
  endtask

  task automatic enq(input logic [7:0] d, output logic acc);
    @(negedge clk);
    txfifo_data  = d;
    txfifo_valid = 1'b1;
    #1 acc = txfifo_ready;
    @(posedge clk);
    #1 txfifo_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(sb.size() == 0 && !busy && mstate == 0) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < BUDGET) ? 1 : 0, 1);
  endtask

  task automatic wait_mon(input int st, input int bits, input string name);
    int n = 0;
    while (!(mstate == st && (st != 1 || mbits == bits)) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < BUDGET) ? 1 : 0, 1);
  endtask

  initial begin
    logic acc;
    int   fd0, b0, f0, stall_bad;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h7F, 1'b1};
    vecs[6] = '{8'hA5, 1'b0};
    vecs[7] = '{8'h3C, 1'b0};

    tck_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_full", txfifo_full, 0);
    check("reset_empty", txfifo_empty, 1);
    check("reset_ready", txfifo_ready, 1);
    check("reset_irq", tx_irq_flags, 2'b10);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_tx", tx, 1);

    for (int i = 0; i < 8; i++) begin
      fd0 = fd_count;
      push(vecs[i].data, vecs[i].par);
      enq(vecs[i].data, acc);
      check("vec_accept", acc, 1);
      wait_idle("vec_complete");
      check("vec_busy_after", busy, 0);
      check("vec_empty_after", txfifo_empty, 1);
      check("vec_frame_done_count", fd_count - fd0, 1);
    end

    fd0 = fd_count;
    b0  = b2b;
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    enq(8'hA5, acc);
    check("b2b_accept0", acc, 1);
    enq(8'h3C, acc);
    check("b2b_accept1", acc, 1);
    wait_idle("b2b_complete");
    check("b2b_no_gap", b2b - b0, 1);
    check("b2b_frame_done_count", fd_count - fd0, 2);

    tck_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      push(8'h10 + 8'(i), 1'b1 ^ ((i & 1) != 0) ^ ((i & 2) != 0) ^ ((i & 4) != 0));
      enq(8'h10 + 8'(i), acc);
      check("full_accept", acc, 1);
    end
    @(negedge clk);
    txfifo_data  = 8'h18;
    txfifo_valid = 1'b1;
    #1;
    check("full_ready_low", txfifo_ready, 0);
    check("full_flag", txfifo_full, 1);
    check("full_irq_empty", tx_irq_flags.fifo_empty, 0);
    @(posedge clk);
    #1 txfifo_valid = 1'b0;
    check("full_still_full", txfifo_full, 1);
    check("full_tx_frozen", tx, 1);
    tck_en = 1'b1;
    wait_idle("full_drain");
    check("full_empty_after", txfifo_empty, 1);

    push(8'hC3, 1'b0);
    enq(8'hC3, acc);
    wait_mon(1, 3, "rst_reach_bit3");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_tx_high", tx, 1);
    check("rst_empty", txfifo_empty, 1);
    check("rst_busy", busy, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = frames;
    repeat (500) @(negedge clk);
    check("rst_no_spurious_frame", frames - f0, 0);
    check("rst_idle_tx", tx, 1);
    push(8'h7E, 1'b0);
    enq(8'h7E, acc);
    check("rst_new_accept", acc, 1);
    wait_idle("rst_new_complete");

    push(8'h96, 1'b0);
    enq(8'h96, acc);
    wait_mon(2, 0, "stall_reach_parity");
    @(posedge clk);
    #1 tck_en = 1'b0;
    stall_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b0) stall_bad++;
    end
    check("stall_tx_hold", stall_bad, 0);
    check("stall_busy", busy, 1);
    tck_en = 1'b1;
    wait_idle("stall_complete");
    check("stall_final_tx", tx, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
